uart_tx_arb: RTL
================

# uart_tx_arb

- Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte producers.
- Sits between the producers and the transmitter's `tx_start`/`tx_data`/`tx_busy` handshake.
- Issues one byte per grant, waits for the frame to complete, optionally enforces an inter-frame gap, then rotates priority.
- Also guards against a transmitter that never acknowledges a start.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CLKS`, 0: idle clocks inserted after each frame; 0 means no gap.
- `TIMEOUT_CLKS`, 16: clocks allowed for `tx_busy` to rise after `tx_start`; must be ≥ 2.
- `tx_clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  byte pending, one bit per requester.
- `req_data`  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  one-cycle start pulse.
- `tx_busy`  in  1  transmitter frame in progress.
- `grant_id`  out  3  index of the current or last granted requester.
- `err_timeout`  out  1  one-cycle pulse when `tx_busy` fails to rise.

## Operation
- State machine, 2 bits: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- Internal registers:
  - `rr_ptr` (3 bits, reset 0) is the highest-priority index.
  - `cnt` (8 bits) is shared by the timeout and gap timing.
- **IDLE**
  - If any `req_valid` is set, the winner w is the first set bit scanning upward from `rr_ptr`, wrapping at NUM_REQ-1 to 0.
  - On that edge, register: `tx_data` = byte w, `grant_id` = w, `req_ready[w]` = 1, `tx_start` = 1, `cnt` = 0, state = WAIT_BUSY.
  - If no `req_valid` is set, stay in IDLE.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise, if `cnt` = TIMEOUT_CLKS-1, pulse `err_timeout`, set `rr_ptr` = (w+1) mod NUM_REQ, and go to IDLE; the byte is dropped and is not retried.
  - Otherwise, increment `cnt`.
- **WAIT_DONE**
  - When `tx_busy`=0, set `rr_ptr` = (w+1) mod NUM_REQ and `cnt` = 0.
  - Then go to GAP if GAP_CLKS>0, else to IDLE.
- **GAP**: increment `cnt`; at `cnt` = GAP_CLKS-1, go to IDLE.
- Handshake rules:
  - A transfer occurs in the cycle where `req_valid[i]` and `req_ready[i]` are both high.
  - A requester holds `req_valid` and data stable until it sees `req_ready`.
  - `req_ready` is never asserted to a requester whose `req_valid` was low at the grant edge.
- A `req_valid` that drops before the grant edge is simply not considered; this is not an error.
- `tx_busy` already high in IDLE is ignored. The arbiter relies on the WAIT_DONE → IDLE sequence, never on a level seen in IDLE.
- Reset, including mid-frame:
  - All outputs clear immediately: `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `err_timeout`=0.
  - State returns to IDLE, `rr_ptr`=0, `cnt`=0.
- Modulo arithmetic on `rr_ptr` wraps explicitly at NUM_REQ. It must not rely on 3-bit overflow, because NUM_REQ may not be a power of two.

## Timing
- Grant latency: `req_valid` sampled high at edge k in IDLE → `req_ready`/`tx_start` high in the cycle after edge k, low after edge k+1.
- Minimum clocks between consecutive `tx_start` pulses: 1 (WAIT_BUSY) + busy duration + 1 (WAIT_DONE exit) + GAP_CLKS + 1 (IDLE decision).
- `err_timeout` is asserted TIMEOUT_CLKS cycles after `tx_start` when `tx_busy` stays low.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (NUM_REQ bits).
  - At WAIT_DONE exit, if `req_lock[w]` and `req_valid[w]` are both high, `rr_ptr` stays at w. w therefore wins the next IDLE decision, so multi-byte messages go out unbroken.
  - GAP is still applied.
  - Lock is ignored on the timeout path.
- `UART_ARB_LOCK_EN` not defined:
  - The port is absent.
  - Pure round-robin applies.

## Structure
- Shared package `uart_pkg` holds:
  - State encodings IDLE=2'b00, WAIT_BUSY=2'b01, WAIT_DONE=2'b10, GAP=2'b11.
  - The byte width constant (8).
  - The `grant_id` width constant (3).
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: winner index and an any-valid flag.
  - Instantiated once.

## Test plan
- Single requester: NUM_REQ=4, req 2 valid with 8'hA5, model busy high for 10 clocks from the clock after start → one `tx_start`, `tx_data`=8'hA5, `grant_id`=2, `req_ready`=4'b0100 for exactly one cycle.
- All four requesters valid continuously, bytes 8'h10..8'h13 → grant order 0,1,2,3,0; no two `tx_start` pulses while `tx_busy` is high.
- `rr_ptr`=3 with requesters 1 and 3 valid → 3 granted first, then 1 (wrap-around).
- Transmitter model never raises busy, TIMEOUT_CLKS=16 → `err_timeout` pulses 16 clocks after `tx_start`; the next grant goes to the following requester.
- GAP_CLKS=5 → exactly 5 IDLE-free clocks between `tx_busy` falling and the next IDLE decision. `rst_n` dropped mid-WAIT_DONE → all outputs 0 asynchronously, and the first grant after reset goes to requester 0.
- With `UART_ARB_LOCK_EN`: req 1 locked and valid alongside req 0/2 → req 1 granted on consecutive frames until its lock drops, then req 2 is granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int BYTE_W   = 8;
  localparam int GID_W    = 3;
  localparam int ID_SPACE = 1 << GID_W;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } arb_state_e;

  // Wraps at n explicitly so non-power-of-two requester counts rotate correctly.
  function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [GID_W-1:0]   winner,
  output logic               any_valid
);

  logic [ID_SPACE-1:0] valid_ext;
  logic [GID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  hit;

  assign valid_ext = ID_SPACE'(req_valid);
  assign any_valid = |req_valid;

  // Candidate gi is the requester gi places after the pointer.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [GID_W:0] sum;
    assign sum          = {1'b0, rr_ptr} + (GID_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (GID_W+1)'(NUM_REQ)) ? GID_W'(sum - (GID_W+1)'(NUM_REQ))
                                                      : sum[GID_W-1:0];
    assign hit[gi]      = valid_ext[cand_idx[gi]];
  end

  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand_idx[k];
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional UART_ARB_LOCK_EN adds req_lock so a requester can keep priority across frames.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 16
) (
  input  logic                      tx_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      err_timeout
);

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic                err_timeout_q, err_timeout_d;

  logic [GID_W-1:0]    winner;
  logic                any_valid;
  logic                lock_hold;
  logic [BYTE_W-1:0]   req_bytes [ID_SPACE];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Pad the byte table to the full id space so a 3-bit index never selects out of range.
  genvar gi;
  for (gi = 0; gi < ID_SPACE; gi++) begin : g_bytes
    if (gi < NUM_REQ) begin : g_real
      assign req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end else begin : g_pad
      assign req_bytes[gi] = '0;
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic [ID_SPACE-1:0] lock_ext, valid_ext;
  assign lock_ext  = ID_SPACE'(req_lock);
  assign valid_ext = ID_SPACE'(req_valid);
  assign lock_hold = lock_ext[grant_id_q] & valid_ext[grant_id_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    grant_id_d    = grant_id_q;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          tx_data_d   = req_bytes[winner];
          grant_id_d  = winner;
          req_ready_d = NUM_REQ'(1) << winner;
          tx_start_d  = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Dropped byte: lock is deliberately not honoured here.
          err_timeout_d = 1'b1;
          rr_ptr_d      = next_idx(grant_id_q, NUM_REQ);
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          rr_ptr_d = lock_hold ? grant_id_q : next_idx(grant_id_q, NUM_REQ);
          cnt_d    = '0;
          state_d  = (GAP_CLKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      grant_id_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      grant_id_q    <= grant_id_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;

endmodule
